// File: rtl/result_pixel_collector.sv
// result_pixel_collector: collects processed pixels from the CellProcessor
// result port into a small FWFT FIFO and re-emits each one as a zero-extended
// 32-bit word on a valid/ready stream. It counts pixels against a per-frame
// length, pulses done for one cycle when the frame completes, and keeps a
// sticky flag for any pixel that had to be dropped.
// Optional feature: define RESULT_CHECKSUM_EN to add a 32-bit running sum of
// the pushed pixels on the extra port 'checksum'.
module result_pixel_collector #(
  parameter int PIXEL_W    = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              frame_len,
  input  logic                          in_valid,
  input  logic [PIXEL_W-1:0]            in_pixel,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow_err
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [PIXEL_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]        wptr, rptr;
  logic [LEN_W-1:0]   len, rx_cnt, tx_cnt;
  logic               full, empty, push, pop, accept_start;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fifo_count = wptr - rptr;

  assign in_ready   = (state == RUN) && !full && (rx_cnt < len);
  assign push       = in_valid && in_ready;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign out_last   = out_valid && (tx_cnt == len - 1'b1);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);

  // The head is masked while empty so stale storage never shows on the bus.
  assign out_data   = out_valid ? 32'(mem[rptr[AW-1:0]]) : '0;

  // Next-state logic and the start-acceptance strobe.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = (frame_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push && (rx_cnt == len - 1'b1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave on the cycle of the final pop so done follows it directly.
        if ((tx_cnt == len) || (pop && (tx_cnt == len - 1'b1))) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FIFO read/write pointers; reset discards any buffered pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_pixel;
  end

  // Frame length latch and received/transmitted pixel counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len    <= '0;
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else if (accept_start) begin
      len    <= frame_len;
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (push) rx_cnt <= rx_cnt + 1'b1;
      if (pop)  tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // Sticky drop flag: the source cannot stall, so a refused pixel is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_err <= 1'b0;
    end else if (accept_start) begin
      overflow_err <= 1'b0;
    end else if (((state == RUN) && in_valid && !in_ready) ||
                 ((state == DRAIN) && in_valid)) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef RESULT_CHECKSUM_EN
  // Running modulo-2^32 sum of every pushed pixel in the current frame.
  always_ff @(posedge clk) begin
    if (!rst)              checksum <= '0;
    else if (accept_start) checksum <= '0;
    else if (push)         checksum <= checksum + 32'(in_pixel);
  end
`endif

endmodule
